// File: rtl/dma_pkg.sv
// Shared definitions for the DMA copy engine: FSM encodings, descriptor layout.
package dma_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_DESC_REQ  = 4'd1;
    localparam logic [3:0] ST_DESC_WAIT = 4'd2;
    localparam logic [3:0] ST_CHECK     = 4'd3;
    localparam logic [3:0] ST_RD_REQ    = 4'd4;
    localparam logic [3:0] ST_RD_WAIT   = 4'd5;
    localparam logic [3:0] ST_WR        = 4'd6;
    localparam logic [3:0] ST_NEXT      = 4'd7;
    localparam logic [3:0] ST_DONE      = 4'd8;

    // A descriptor is four consecutive words: {src, dst, len_words, next_ptr}.
    localparam int          DESC_WORDS    = 4;
    localparam logic [31:0] DESC_OFF_SRC  = 32'd0;
    localparam logic [31:0] DESC_OFF_DST  = 32'd4;
    localparam logic [31:0] DESC_OFF_LEN  = 32'd8;
    localparam logic [31:0] DESC_OFF_NEXT = 32'd12;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
    } desc_fields_t;

    // Byte offset of descriptor word idx within a descriptor.
    function automatic logic [31:0] desc_offset(input logic [1:0] idx);
        case (idx)
            2'd0:    desc_offset = DESC_OFF_SRC;
            2'd1:    desc_offset = DESC_OFF_DST;
            2'd2:    desc_offset = DESC_OFF_LEN;
            default: desc_offset = DESC_OFF_NEXT;
        endcase
    endfunction

endpackage

// File: rtl/dma_copy_engine_desc_fetch.sv
// Descriptor word sequencer: tracks which of the four words is being fetched,
// drives the request/address, and captures src/dst/len as acks arrive.
// The next_ptr word (last) is taken directly from the ack data by the top.
module dma_desc_fetch
    import dma_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] ptr,
    input  logic        req_next,
    input  logic        ack_take,
    input  logic [31:0] ack_data,
    output logic        desc_read_req,
    output logic [31:0] desc_read_addr,
    output logic        last_word,
    output logic [31:0] desc_src,
    output logic [31:0] desc_dst,
    output logic [31:0] desc_len
);
    logic [31:0]  base_r;
    logic [31:0]  addr_r;
    logic [1:0]   idx_r;
    logic         req_r;
    desc_fields_t fields_r;

    assign desc_read_req  = req_r;
    assign desc_read_addr = addr_r;
    assign last_word      = (idx_r == 2'(DESC_WORDS - 1));
    assign desc_src       = fields_r.src;
    assign desc_dst       = fields_r.dst;
    assign desc_len       = fields_r.len;

    // Word index and address: restart at a new descriptor, advance on each ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= 32'd0;
            addr_r <= 32'd0;
            idx_r  <= 2'd0;
        end else if (load) begin
            base_r <= ptr;
            addr_r <= ptr + desc_offset(2'd0);
            idx_r  <= 2'd0;
        end else if (ack_take) begin
            addr_r <= base_r + desc_offset(idx_r + 2'd1);
            idx_r  <= idx_r + 2'd1;
        end
    end

    // Request strobe is a registered copy of "FSM is entering DESC_REQ".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r <= 1'b0;
        end else begin
            req_r <= req_next;
        end
    end

    // Capture descriptor fields in word order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fields_r <= '0;
        end else if (ack_take) begin
            case (idx_r)
                2'd0:    fields_r.src <= ack_data;
                2'd1:    fields_r.dst <= ack_data;
                2'd2:    fields_r.len <= ack_data;
                default: fields_r     <= fields_r;
            endcase
        end
    end

endmodule

// File: rtl/dma_copy_engine.sv
// Single-channel word-copy DMA engine: register mode or linked-descriptor walk,
// one read then one write per word, with a sticky done flag and an irq pulse.
module dma_copy_engine
    import dma_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_DESC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [63:0]   src_addr,
    input  logic [63:0]   dst_addr,
    input  logic [31:0]   len,
    input  logic          desc_mode,
    input  logic [31:0]   desc_ptr,
    input  logic          src_resident,
    input  logic          dst_resident,
    output logic          done,
    output logic          irq,
    output logic          mem_read_en,
    output logic [AW-1:0] mem_read_addr,
    input  logic [DW-1:0] mem_read_data,
    input  logic          mem_read_valid,
    output logic          mem_write_en,
    output logic [AW-1:0] mem_write_addr,
    output logic [DW-1:0] mem_write_data,
    output logic          desc_read_req,
    output logic [31:0]   desc_read_addr,
    input  logic          desc_read_ack,
    input  logic [31:0]   desc_read_data
);
    localparam int CW = $clog2(MAX_DESC + 1);

    logic [3:0]    state_r, state_next;
    logic [AW-1:0] cur_src_r, cur_dst_r;
    logic [31:0]   remaining_r, next_ptr_r;
    logic          desc_mode_r;
    logic [CW-1:0] desc_cnt_r;
    logic [DW-1:0] rd_data_r;
    logic          done_r, irq_r, rd_en_r, wr_en_r;
    logic          start_ok, fetch_take, fetch_last, fetch_load, enter_done, last_word;
    logic [31:0]   fetch_ptr, f_src, f_dst, f_len;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{src_addr[63:AW], dst_addr[63:AW]};

    assign start_ok   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign fetch_take = (state_r == ST_DESC_WAIT) && desc_read_ack;
    assign fetch_last = fetch_take && last_word;
    assign fetch_load = (start_ok && desc_mode) || ((state_r == ST_NEXT) && (state_next == ST_DESC_REQ));
    assign fetch_ptr  = (state_r == ST_NEXT) ? next_ptr_r : desc_ptr;
    assign enter_done = (state_next == ST_DONE) && (state_r != ST_DONE);

    assign done           = done_r;
    assign irq            = irq_r;
    assign mem_read_en    = rd_en_r;
    assign mem_read_addr  = cur_src_r;
    assign mem_write_en   = wr_en_r;
    assign mem_write_addr = cur_dst_r;
    assign mem_write_data = rd_data_r;

    dma_desc_fetch u_desc_fetch (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (fetch_load),
        .ptr            (fetch_ptr),
        .req_next       (state_next == ST_DESC_REQ),
        .ack_take       (fetch_take),
        .ack_data       (desc_read_data),
        .desc_read_req  (desc_read_req),
        .desc_read_addr (desc_read_addr),
        .last_word      (last_word),
        .desc_src       (f_src),
        .desc_dst       (f_dst),
        .desc_len       (f_len)
    );

    // Next-state decode; stray valid/ack outside the wait states fall through.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = desc_mode ? ST_DESC_REQ : ST_CHECK;
                else       state_next = state_r;
            end
            ST_DESC_REQ:  state_next = ST_DESC_WAIT;
            ST_DESC_WAIT: begin
                if (desc_read_ack) state_next = last_word ? ST_CHECK : ST_DESC_REQ;
                else               state_next = ST_DESC_WAIT;
            end
            ST_CHECK: begin
                if (!(src_resident && dst_resident)) state_next = ST_DONE;
                else if (remaining_r == 32'd0)       state_next = ST_NEXT;
                else                                 state_next = ST_RD_REQ;
            end
            ST_RD_REQ:  state_next = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (mem_read_valid) state_next = ST_WR;
                else                state_next = ST_RD_WAIT;
            end
            ST_WR: begin
                if (remaining_r != 32'd1) state_next = ST_RD_REQ;
                else                      state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (desc_mode_r && (next_ptr_r != 32'd0) && (desc_cnt_r < CW'(MAX_DESC)))
                    state_next = ST_DESC_REQ;
                else
                    state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register plus strobes registered from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            rd_en_r <= 1'b0;
            wr_en_r <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            state_r <= state_next;
            rd_en_r <= (state_next == ST_RD_REQ);
            wr_en_r <= (state_next == ST_WR);
            irq_r   <= enter_done;
        end
    end

    // Sticky done: cleared by an accepted start, set on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          done_r <= 1'b0;
        else if (start_ok)   done_r <= 1'b0;
        else if (enter_done) done_r <= 1'b1;
        else                 done_r <= done_r;
    end

    // Transfer context: latched at start or from a fetched descriptor, stepped per word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_src_r   <= '0;
            cur_dst_r   <= '0;
            remaining_r <= 32'd0;
            next_ptr_r  <= 32'd0;
            desc_mode_r <= 1'b0;
            desc_cnt_r  <= '0;
            rd_data_r   <= '0;
        end else if (start_ok) begin
            cur_src_r   <= src_addr[AW-1:0];
            cur_dst_r   <= dst_addr[AW-1:0];
            remaining_r <= len;
            next_ptr_r  <= 32'd0;
            desc_mode_r <= desc_mode;
            desc_cnt_r  <= '0;
        end else if (fetch_last) begin
            cur_src_r   <= AW'(f_src);
            cur_dst_r   <= AW'(f_dst);
            remaining_r <= f_len;
            next_ptr_r  <= desc_read_data;
            desc_cnt_r  <= desc_cnt_r + CW'(1);
        end else if ((state_r == ST_RD_WAIT) && mem_read_valid) begin
            rd_data_r   <= mem_read_data;
        end else if (state_r == ST_WR) begin
            cur_src_r   <= cur_src_r + AW'(4);
            cur_dst_r   <= cur_dst_r + AW'(4);
            remaining_r <= remaining_r - 32'd1;
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: memory/descriptor responders, registered mmu
// residency models and a write scoreboard fed from the bench's memory image.
module tb_dma_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] src_addr = 64'd0, dst_addr = 64'd0;
    logic [31:0] len = 32'd0, desc_ptr = 32'd0;
    logic        desc_mode = 1'b0;
    logic        src_resident = 1'b0, dst_resident = 1'b0;
    logic        done, irq, mem_read_en, mem_write_en, desc_read_req;
    logic [31:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;
    logic        mem_read_valid, desc_read_ack;
    logic [31:0] desc_read_addr, desc_read_data;

    always #5 clk = ~clk;

    dma_copy_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .desc_mode(desc_mode), .desc_ptr(desc_ptr),
        .src_resident(src_resident), .dst_resident(dst_resident),
        .done(done), .irq(irq),
        .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .desc_read_req(desc_read_req), .desc_read_addr(desc_read_addr),
        .desc_read_ack(desc_read_ack), .desc_read_data(desc_read_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory image (source data and descriptors); DUT writes go to the scoreboard.
    logic [31:0] img [0:1023];
    int          lat = 1;

    // mmu models: residency of the driven addresses, registered.
    always @(posedge clk) begin
        src_resident <= (src_addr < 64'h1_0000_0000);
        dst_resident <= (dst_addr < 64'h1_0000_0000);
    end

    // Read pipeline: data valid 'lat' cycles after mem_read_en.
    logic        rp_v [0:3];
    logic [31:0] rp_a [0:3];
    logic [31:0] rd_a;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin rp_v[i] <= 1'b0; rp_a[i] <= 32'd0; end
        end else begin
            rp_v[0] <= mem_read_en;
            rp_a[0] <= mem_read_addr;
            for (int i = 1; i < 4; i++) begin rp_v[i] <= rp_v[i-1]; rp_a[i] <= rp_a[i-1]; end
        end
    end
    assign rd_a           = rp_a[lat-1];
    assign mem_read_valid = rp_v[lat-1];
    assign mem_read_data  = img[rd_a[11:2]];

    // Descriptor responder: ack two cycles after each request.
    logic        dp_v [0:1];
    logic [31:0] dp_a [0:1];
    logic [31:0] dk_a;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_v[0] <= 1'b0; dp_v[1] <= 1'b0; dp_a[0] <= 32'd0; dp_a[1] <= 32'd0;
        end else begin
            dp_v[0] <= desc_read_req; dp_a[0] <= desc_read_addr;
            dp_v[1] <= dp_v[0];       dp_a[1] <= dp_a[0];
        end
    end
    assign dk_a           = dp_a[1];
    assign desc_read_ack  = dp_v[1];
    assign desc_read_data = img[dk_a[11:2]];

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t exp_q [$];
    wr_t e;
    int  rd_cnt = 0, wr_cnt = 0, dreq_cnt = 0, irq_cnt = 0;
    int  rd0, wr0, dq0, irq0;
    logic seen_valid = 1'b0, prev_irq = 1'b0;

    // Output monitor on the falling edge: scoreboard, port exclusivity, pulse widths.
    always @(negedge clk) begin
        if (mem_write_en) begin
            check_val("rd_before_wr", seen_valid, 1);
            check_val("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("wr_addr", mem_write_addr, e.a);
                check_val("wr_data", mem_write_data, e.d);
            end
        end
        if (mem_read_en | desc_read_req) check_val("port_excl", mem_read_en & desc_read_req, 0);
        if (irq) check_val("irq_width", prev_irq, 0);
        if (mem_read_en)         seen_valid <= 1'b0;
        else if (mem_read_valid) seen_valid <= 1'b1;
        prev_irq <= irq;
        rd_cnt   <= rd_cnt + int'(mem_read_en);
        wr_cnt   <= wr_cnt + int'(mem_write_en);
        dreq_cnt <= dreq_cnt + int'(desc_read_req);
        irq_cnt  <= irq_cnt + int'(irq);
    end

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{d + 32'(4*i), img[s[11:2] + 10'(i)]});
    endtask

    task automatic snap();
        rd0 = rd_cnt; wr0 = wr_cnt; dq0 = dreq_cnt; irq0 = irq_cnt;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin @(negedge clk); n++; end
        check_val(tag, done, 1);
    endtask

    task automatic end_test(input string tag, input int erd, input int ewr, input int edq);
        repeat (3) @(negedge clk);
        check_val({tag, "_reads"},  rd_cnt - rd0, erd);
        check_val({tag, "_writes"}, wr_cnt - wr0, ewr);
        check_val({tag, "_dreqs"},  dreq_cnt - dq0, edq);
        check_val({tag, "_irqs"},   irq_cnt - irq0, 1);
        check_val({tag, "_done"},   done, 1);
        check_val({tag, "_sb_left"}, exp_q.size(), 0);
    endtask

    // Timeout guard.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit hit;
        for (int i = 0; i < 1024; i++) img[i] = 32'hDEAD_0000 + 32'(i);
        img[64] = 32'd1; img[65] = 32'd2; img[66] = 32'd3; img[67] = 32'd4;
        img[16] = 32'h100; img[17] = 32'h300; img[18] = 32'd2; img[19] = 32'h50;
        img[20] = 32'h108; img[21] = 32'h308; img[22] = 32'd1; img[23] = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_done", done, 0);
        check_val("rst_irq", irq, 0);
        check_val("rst_rd_en", mem_read_en, 0);
        check_val("rst_wr_en", mem_write_en, 0);
        check_val("rst_dreq", desc_read_req, 0);
        check_val("rst_wr_addr", mem_write_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Register-mode copy of 4 words
        src_addr = 64'h100; dst_addr = 64'h200; len = 32'd4;
        @(negedge clk);
        snap(); push_copy(32'h100, 32'h200, 4);
        pulse_start();
        wait_done("reg_copy_done", 200);
        end_test("reg_copy", 4, 4, 0);

        // Zero length: no traffic, irq within 3 cycles
        len = 32'd0;
        snap();
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (irq) hit = 1'b1; end
        check_val("len0_irq_latency", hit, 1);
        wait_done("len0_done", 20);
        end_test("len0", 0, 0, 0);

        // Non-resident source: aborted, no traffic
        src_addr = 64'h1_0000_0000; len = 32'd2;
        @(negedge clk);
        snap();
        pulse_start();
        wait_done("fault_done", 50);
        end_test("fault", 0, 0, 0);

        // Descriptor chain 0x40 -> 0x50
        src_addr = 64'd0; dst_addr = 64'd0; desc_mode = 1'b1; desc_ptr = 32'h40;
        @(negedge clk);
        snap(); push_copy(32'h100, 32'h300, 2); push_copy(32'h108, 32'h308, 1);
        pulse_start();
        wait_done("desc_done", 400);
        end_test("desc", 3, 3, 8);

        // Latency 3 with an ignored start mid-transfer
        desc_mode = 1'b0; lat = 3; src_addr = 64'h100; dst_addr = 64'h400; len = 32'd4;
        @(negedge clk);
        snap(); push_copy(32'h100, 32'h400, 4);
        pulse_start();
        repeat (6) @(negedge clk);
        pulse_start();
        wait_done("lat3_done", 300);
        end_test("lat3", 4, 4, 0);

        // Reset mid-copy, then a fresh transfer
        lat = 1; dst_addr = 64'h500;
        @(negedge clk);
        snap(); push_copy(32'h100, 32'h500, 4);
        pulse_start();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_rd_en", mem_read_en, 0);
        check_val("arst_wr_en", mem_write_en, 0);
        check_val("arst_dreq", desc_read_req, 0);
        check_val("arst_done", done, 0);
        check_val("arst_irq", irq, 0);
        check_val("arst_rd_addr", mem_read_addr, 0);
        repeat (3) @(negedge clk);
        check_val("arst_no_irq", irq_cnt - irq0, 0);
        exp_q.delete();
        rst_n = 1'b1;
        dst_addr = 64'h600; len = 32'd2;
        @(negedge clk);
        snap(); push_copy(32'h100, 32'h600, 2);
        pulse_start();
        wait_done("post_rst_done", 200);
        end_test("post_rst", 2, 2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
